// File: rtl/serial_subtractor_pkg.sv
// Shared constants and types for the bit-serial subtractor.
package serial_subtractor_pkg;

  // FSM state encodings
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_SHIFT = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = STATE_IDLE,
    StShift = STATE_SHIFT,
    StDone  = STATE_DONE
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Per-bit difference and borrow equations
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B one bit per cycle, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  // Counter must be able to hold WIDTH itself without wrapping
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_full_subtractor (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // New difference bit enters at the MSB so the LSB-first stream lands in place
  assign res_next = {bit_d, res_q[WIDTH-1:1]};

  // Next-state logic: operand capture, per-bit shift and result load
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next;
        brw_d = bit_bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d   = res_next;
          borrow_d = bit_bout;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a timing/arithmetic model pushes
// expected results on accepted starts; a negedge monitor compares outputs.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;

  serial_subtractor #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Diff   (Diff),
    .Borrow (Borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation occupies WIDTH cycles after acceptance,
  // result is plain modular subtraction and an unsigned compare.
  logic [WIDTH:0]   exp_q[$];
  int               m_remaining = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_borrow = 1'b0;
  int               m_underflow = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_remaining = 0;
      m_done      = 1'b0;
      m_diff      = '0;
      m_borrow    = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_remaining > 0) begin
        m_remaining--;
        if (m_remaining == 0) begin
          if (exp_q.size() == 0) begin
            m_underflow++;
          end else begin
            logic [WIDTH:0] e;
            e        = exp_q.pop_front();
            m_diff   = e[WIDTH-1:0];
            m_borrow = e[WIDTH];
            m_done   = 1'b1;
          end
        end
      end else if (start) begin
        int unsigned ua, ub;
        logic [WIDTH-1:0] d;
        ua = A;
        ub = B;
        d  = WIDTH'(ua - ub);
        exp_q.push_back({(ua < ub), d});
        m_remaining = WIDTH;
      end
    end
  end

  // Monitor: compare every cycle away from the active edge
  int cycle = 0;
  int busy_run = 0;
  bit streaming = 1'b0;
  int last_done = -1;
  int done_count = 0;

  always @(negedge clk) begin
    cycle++;
    check("busy", 32'(busy), 32'(m_remaining > 0));
    check("done", 32'(done), 32'(m_done));
    check("Diff", 32'(Diff), 32'(m_diff));
    check("Borrow", 32'(Borrow), 32'(m_borrow));
    if (done) begin
      done_count++;
      check("busy_len", busy_run, WIDTH);
      if (streaming && last_done >= 0) check("done_gap", cycle - last_done, WIDTH + 1);
      last_done = cycle;
    end
    if (busy) busy_run++;
    else busy_run = 0;
  end

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int dc;
    // Reset with start asserted: reset must win
    rst_n = 1'b0; start = 1'b1; A = 8'hFF; B = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);

    op(8'h05, 8'h03);
    check("dir_05_03", {23'd0, Borrow, Diff}, {23'd0, 1'b0, 8'h02});
    op(8'h03, 8'h05);
    check("dir_03_05", {23'd0, Borrow, Diff}, {23'd0, 1'b1, 8'hFE});
    op(8'h00, 8'h00);
    check("dir_00_00", {23'd0, Borrow, Diff}, {23'd0, 1'b0, 8'h00});

    // Start during busy cycle 4 must be ignored
    @(posedge clk); #1;
    A = 8'hFF; B = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 A = 8'h10; B = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = done_count;
    wait_done();
    check("ignored_start", {23'd0, Borrow, Diff}, {23'd0, 1'b0, 8'hFE});
    repeat (12) @(posedge clk);
    check("single_done", done_count - dc, 1);

    // Start held high: back-to-back results every WIDTH+1 cycles
    @(posedge clk); #1;
    A = 8'h80; B = 8'h7F; start = 1'b1; streaming = 1'b1; last_done = -1;
    dc = done_count;
    repeat (45) @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    streaming = 1'b0;
    check("stream_dones", done_count - dc, 5);

    // Reset during busy cycle 3 aborts with no done
    @(posedge clk); #1;
    A = 8'hAA; B = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    dc = done_count;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {29'd0, busy, done, Borrow}, 32'd0);
    check("abort_diff", 32'(Diff), 32'd0);
    repeat (20) @(posedge clk);
    check("abort_no_done", done_count - dc, 0);

    // Randomized traffic including starts while busy and occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(3) == 0);
      A     = WIDTH'($urandom);
      B     = WIDTH'($urandom);
      rst_n = ($urandom_range(149) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    repeat (20) @(posedge clk);
    check("model_underflow", m_underflow, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
